// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave fronting a word-organised on-chip SRAM.
// Programmable wait states, byte/halfword/word lane writes, pipelined
// address/data phases. Optional two-cycle ERROR response for bad transfers
// is built when the macro AHB_SRAM_ERR_EN is defined; without it HRESP is
// tied low and bad transfers complete as OKAY with no memory effect.
module ahb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST
`ifdef AHB_SRAM_ERR_EN
    ,
    ST_ERR1,
    ST_ERR2
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      lanes_q, lanes_d;
  logic            write_q, write_d;
  logic            bad_q, bad_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH];

  logic [3:0]      dec_lanes;
  logic            dec_misalign;
  logic            dec_range;
  logic            dec_bad;
  logic            hready_int;
  logic            commit;
  logic [31:0]     rd_word;

  // HTRANS[0] only separates NONSEQ from SEQ, which are treated alike.
  logic            unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // Decode the address-phase size/offset into a lane mask and alignment fault.
  always_comb begin
    dec_lanes    = 4'b0000;
    dec_misalign = 1'b0;
    case (HSIZE)
      3'b000: dec_lanes = 4'b0001 << HADDR[1:0];
      3'b001: begin
        dec_lanes    = HADDR[1] ? 4'b1100 : 4'b0011;
        dec_misalign = HADDR[0];
      end
      3'b010: begin
        dec_lanes    = 4'b1111;
        dec_misalign = (HADDR[1:0] != 2'b00);
      end
      default: dec_misalign = 1'b1;
    endcase
  end

  assign dec_range = ({2'b00, HADDR[31:2]} >= 32'(DEPTH));
  assign dec_bad   = dec_misalign | dec_range;

  // Next-state, wait counter and address-phase capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    lanes_d    = lanes_q;
    write_d    = write_q;
    bad_d      = bad_q;
    hready_int = 1'b1;
    case (state_q)
      ST_WAIT: begin
        hready_int = 1'b0;
        if (cnt_q == 4'd0) state_d = ST_LAST;
        else               cnt_d   = cnt_q - 4'd1;
      end
`ifdef AHB_SRAM_ERR_EN
      ST_ERR1: begin
        hready_int = 1'b0;
        state_d    = ST_ERR2;
      end
`endif
      default: ;
    endcase
    // IDLE, LAST and ERR2 all end the data phase, so a new address phase may start.
    if (hready_int) begin
      if (HSEL && HREADY && HTRANS[1]) begin
        idx_d   = HADDR[AW+1:2];
        lanes_d = dec_lanes;
        write_d = HWRITE;
        bad_d   = dec_bad;
`ifdef AHB_SRAM_ERR_EN
        if (dec_bad) state_d = ST_ERR1;
        else
`endif
        if (WAIT_STATES == 0) begin
          state_d = ST_LAST;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  assign HREADYOUT = hready_int;

`ifdef AHB_SRAM_ERR_EN
  assign HRESP = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
  assign HRESP = 1'b0;
`endif

  // A write lands on the edge that ends its LAST cycle; bad writes never land.
  assign commit = (state_q == ST_LAST) && write_q && !bad_q;

  // Read word for the upcoming LAST, forwarding lanes of a write committing this edge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    assign rd_word[gi*8 +: 8] = (commit && lanes_q[gi] && (idx_q == idx_d)) ?
                                HWDATA[gi*8 +: 8] : mem[idx_d][gi*8 +: 8];
  end

  assign rdata_d = ((state_d == ST_LAST) && !write_d && !bad_d) ? rd_word : 32'h0;

  // Lane-masked write into the array; contents are never reset.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes_q[i]) mem[idx_q][i*8 +: 8] <= HWDATA[i*8 +: 8];
      end
    end
  end

  // Control and read-data registers; reset abandons any pending transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lanes_q <= 4'b0000;
      write_q <= 1'b0;
      bad_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      write_q <= write_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
    end
  end

  assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed checks of ahb_sram_slave on three instances
// (2 wait states / 0 wait states with DEPTH=256 / 3 wait states).
// Expectations for bad transfers follow AHB_SRAM_ERR_EN.
module tb_ahb_sram_slave;

  logic        clk;
  logic        rst_n;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [1:0]  cur;

  logic        hreadyout [3];
  logic        hresp     [3];
  logic [31:0] hrdata    [3];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign hready = (cur == 2'd0) ? hreadyout[0] :
                  (cur == 2'd1) ? hreadyout[1] : hreadyout[2];

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
    .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete NONSEQ transfer to instance s; returns read data, wait count, final HRESP.
  task automatic xfer(input int s, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int waits,
                      output logic resp);
    cur    = 2'(s);
    hsel   = 3'b001 << s;
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    step();
    hsel   = 3'b000;
    htrans = 2'b00;
    hwdata = wd;
    waits  = 0;
    while (hreadyout[s] == 1'b0 && waits < 40) begin
      check_val("rdata_zero_in_wait", hrdata[s], 32'h0);
      waits++;
      step();
    end
    if (waits >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: dut%0d HREADYOUT stuck low after 40 cycles, required high", s);
    end
    rd   = hrdata[s];
    resp = hresp[s];
    step();
    $display("txn dut%0d %s addr=0x%08h size=%0d wdata=0x%08h rdata=0x%08h waits=%0d resp=%0d",
             s, wr ? "WR" : "RD", a, sz, wd, rd, waits, resp);
  endtask

  // Address phase that must be ignored: either HSEL low or BUSY, write to 0x00.
  task automatic ignored_write(input int s, input logic sel, input logic [1:0] trans, input string tag);
    cur    = 2'(s);
    hsel   = sel ? (3'b001 << s) : 3'b000;
    htrans = trans;
    haddr  = 32'h0;
    hwrite = 1'b1;
    hsize  = 3'b010;
    step();
    hsel   = 3'b000;
    htrans = 2'b00;
    hwdata = 32'hBAD0_BAD0;
    check_val({tag, "_ready"}, {31'h0, hreadyout[s]}, 32'h1);
    check_val({tag, "_resp"}, {31'h0, hresp[s]}, 32'h0);
    step();
    $display("txn dut%0d ignored write sel=%0d htrans=%0d", s, sel, trans);
  endtask

  logic [31:0] rd;
  int          waits;
  logic        resp;

  initial begin
    rst_n  = 1'b0;
    hsel   = 3'b000;
    htrans = 2'b00;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hsize  = 3'b000;
    hwdata = 32'h0;
    cur    = 2'd0;
    repeat (2) step();
    check_val("reset_ready", {31'h0, hreadyout[0]}, 32'h1);
    check_val("reset_resp", {31'h0, hresp[0]}, 32'h0);
    check_val("reset_rdata", hrdata[0], 32'h0);
    rst_n = 1'b1;
    step();

    // Two wait states: word write then read back.
    xfer(0, 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, rd, waits, resp);
    check_val("ws2_wr_waits", waits, 2);
    check_val("ws2_wr_resp", {31'h0, resp}, 32'h0);
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, waits, resp);
    check_val("ws2_rd_waits", waits, 2);
    check_val("ws2_rd_data", rd, 32'hDEAD_BEEF);

    // Lane writes.
    xfer(0, 1'b1, 32'h20, 3'b010, 32'h0000_0000, rd, waits, resp);
    xfer(0, 1'b1, 32'h21, 3'b000, 32'h0000_AA00, rd, waits, resp);
    xfer(0, 1'b1, 32'h22, 3'b001, 32'h5555_0000, rd, waits, resp);
    xfer(0, 1'b0, 32'h20, 3'b010, 32'h0, rd, waits, resp);
    check_val("lane_mix", rd, 32'h5555_AA00);
    xfer(0, 1'b1, 32'h24, 3'b010, 32'h1122_3344, rd, waits, resp);
    xfer(0, 1'b1, 32'h27, 3'b000, 32'hCC99_8877, rd, waits, resp);
    xfer(0, 1'b0, 32'h24, 3'b010, 32'h0, rd, waits, resp);
    check_val("lane_byte3", rd, 32'hCC22_3344);

    // Misaligned halfword write is bad and must not touch memory.
    xfer(0, 1'b1, 32'h25, 3'b001, 32'hFFFF_FFFF, rd, waits, resp);
`ifdef AHB_SRAM_ERR_EN
    check_val("misalign_waits", waits, 1);
    check_val("misalign_resp", {31'h0, resp}, 32'h1);
`else
    check_val("misalign_waits", waits, 2);
    check_val("misalign_resp", {31'h0, resp}, 32'h0);
`endif
    xfer(0, 1'b0, 32'h24, 3'b010, 32'h0, rd, waits, resp);
    check_val("misalign_no_write", rd, 32'hCC22_3344);

    // Zero wait states, DEPTH=256.
    xfer(1, 1'b1, 32'h0, 3'b010, 32'hA5A5_A5A5, rd, waits, resp);
    check_val("ws0_wr_waits", waits, 0);
    xfer(1, 1'b0, 32'h400, 3'b010, 32'h0, rd, waits, resp);
`ifdef AHB_SRAM_ERR_EN
    check_val("range_rd_waits", waits, 1);
    check_val("range_rd_resp", {31'h0, resp}, 32'h1);
`else
    check_val("range_rd_waits", waits, 0);
    check_val("range_rd_resp", {31'h0, resp}, 32'h0);
`endif
    check_val("range_rd_data", rd, 32'h0);
    xfer(1, 1'b1, 32'h400, 3'b010, 32'hFFFF_FFFF, rd, waits, resp);
    xfer(1, 1'b0, 32'h0, 3'b010, 32'h0, rd, waits, resp);
    check_val("range_wr_dropped", rd, 32'hA5A5_A5A5);

    // HSEL low and BUSY must not write.
    ignored_write(1, 1'b0, 2'b10, "hsel0");
    ignored_write(1, 1'b1, 2'b01, "busy");
    xfer(1, 1'b0, 32'h0, 3'b010, 32'h0, rd, waits, resp);
    check_val("ignored_mem0", rd, 32'hA5A5_A5A5);

    // Back-to-back write then read of the same word, zero wait states.
    cur    = 2'd1;
    hsel   = 3'b010;
    htrans = 2'b10;
    haddr  = 32'h40;
    hwrite = 1'b1;
    hsize  = 3'b010;
    step();
    check_val("b2b_wr_ready", {31'h0, hreadyout[1]}, 32'h1);
    hwdata = 32'h1234_5678;
    hwrite = 1'b0;
    step();
    check_val("b2b_rd_ready", {31'h0, hreadyout[1]}, 32'h1);
    check_val("b2b_rd_data", hrdata[1], 32'h1234_5678);
    hsel   = 3'b000;
    htrans = 2'b00;
    step();
    check_val("b2b_idle_rdata", hrdata[1], 32'h0);
    $display("txn dut1 back-to-back WR/RD addr=0x00000040");

    // Reset in the middle of a three-wait-state write.
    xfer(2, 1'b1, 32'h30, 3'b010, 32'h5A5A_5A5A, rd, waits, resp);
    check_val("ws3_wr_waits", waits, 3);
    cur    = 2'd2;
    hsel   = 3'b100;
    htrans = 2'b10;
    haddr  = 32'h30;
    hwrite = 1'b1;
    hsize  = 3'b010;
    step();
    hsel   = 3'b000;
    htrans = 2'b00;
    hwdata = 32'hFFFF_FFFF;
    check_val("rst_pre_wait", {31'h0, hreadyout[2]}, 32'h0);
    step();
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_ready", {31'h0, hreadyout[2]}, 32'h1);
    check_val("rst_mid_resp", {31'h0, hresp[2]}, 32'h0);
    check_val("rst_mid_rdata", hrdata[2], 32'h0);
    step();
    rst_n = 1'b1;
    step();
    $display("txn dut2 write aborted by reset addr=0x00000030");
    xfer(2, 1'b0, 32'h30, 3'b010, 32'h0, rd, waits, resp);
    check_val("rst_mem_kept", rd, 32'h5A5A_5A5A);
    check_val("ws3_rd_waits", waits, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-Lite slave with an internal word-organised SRAM array, programmable wait states and byte-lane writes. It replaces the fixed 1024x32, zero-wait, word-only SRAM slave and sits behind the AHB-Lite address decoder as a general-purpose on-chip memory. It also implements full address/data-phase pipelining, HSIZE byte/halfword/word transfers and an optional two-cycle ERROR response.

## Interface
- DEPTH, 1024: number of 32-bit words; any value ≥2, not necessarily a power of two.
- WAIT_STATES, 0: wait cycles inserted in every OKAY data phase (0..15).
- HCLK  in  1  bus clock; all state changes on its rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  byte address, relative to the slave base.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 write, 0 read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HREADY  in  1  bus-level ready; qualifies address-phase sampling.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYOUT  out  1  0 extends the current data phase.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.

## Operation
- A transfer is accepted on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1.
  - On acceptance, HADDR, HWRITE and HSIZE are registered and decoded to the word index HADDR[31:2] and lane mask.
  - SEQ is handled identically to NONSEQ.
- IDLE and BUSY transfers, and any cycle with HSEL=0, get a zero-wait OKAY response and make no memory access.
- Lane mask, from HSIZE and HADDR[1:0]:
  - byte: the single lane selected by addr[1:0].
  - half: lanes 1:0 when addr[1]=0, lanes 3:2 when addr[1]=1.
  - word: all four lanes.
- Bad transfer: word index ≥ DEPTH, misaligned (half with addr[0]=1, word with addr[1:0]≠0), or HSIZE>010.
- FSM states:
  - IDLE: no data phase pending. HREADYOUT=1, HRESP=0.
  - WAIT: counter running. HREADYOUT=0, HRESP=0.
  - LAST: final OKAY data cycle. HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions out of IDLE, LAST or ERR2:
  - accepted bad transfer (ERR_EN build) → ERR1.
  - accepted good transfer with WAIT_STATES=0 → LAST.
  - accepted good transfer with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES-1.
  - no accepted transfer → IDLE.
- WAIT decrements the counter each cycle and moves to LAST after the cycle in which the counter is 0.
- ERR1 always moves to ERR2 on the next edge.
- Write commit: on the edge ending LAST, only the enabled lanes of mem[index] are loaded from the matching HWDATA lanes. Other lanes are unchanged.
- Read data: during LAST of a read, HRDATA = mem[index]. All 32 bits are driven regardless of size. HRDATA=0 in every other state.
- Back-to-back transfers: a new address phase accepted in LAST is serviced with no idle cycle in between.
  - A read that directly follows a write to the same word returns the newly written data, because the write commits before the read's data phase.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, counter 0.
- OKAY data phase length is WAIT_STATES+1 cycles; HREADYOUT is low for exactly WAIT_STATES cycles.
- ERROR response is always two cycles (ERR1, ERR2) whatever WAIT_STATES is. No memory access is made.
- Address-phase inputs are sampled only while HREADY=1. When another slave stalls the bus (HREADY=0 with this slave in IDLE), nothing is sampled.
- Reset asserted mid data phase: the FSM returns to IDLE immediately; any pending write is dropped and memory is untouched.

## Configuration
- AHB_SRAM_ERR_EN defined:
  - Bad transfers take the ERR1→ERR2 path.
  - HRESP is driven by the FSM.
- AHB_SRAM_ERR_EN undefined:
  - HRESP is tied to 0 and the ERR states are not built.
  - Bad transfers complete as normal OKAY transfers with WAIT_STATES timing.
  - Bad writes are discarded.
  - Bad reads return HRDATA=0 in LAST.

## Test plan
- Reset with HRESETn=0 mid-write, WAIT_STATES=3 → HREADYOUT=1, HRESP=0, HRDATA=0 immediately; the target word is unchanged after release.
- WAIT_STATES=2: word write 0xDEADBEEF to 0x10, then read 0x10 → each data phase has HREADYOUT low for 2 cycles; HRDATA=0xDEADBEEF in the third cycle of the read data phase.
- Lane test: word write 0x00000000 to 0x20, then byte write 0xAA at 0x21 (HWDATA=0x0000AA00), then half write 0x5555 at 0x22 → word read returns 0x5555AA00.
- Back-to-back with WAIT_STATES=0: NONSEQ write 0x12345678 to 0x40 immediately followed by a read of 0x40 → read data phase returns 0x12345678 with HREADYOUT=1 throughout.
- DEPTH=256 with ERR_EN: read at 0x400 → ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), HRDATA=0. Without ERR_EN → one OKAY cycle, HRDATA=0.
- HSEL=0 or HTRANS=BUSY with a write to 0x00 → zero-wait OKAY response and mem[0] is unchanged.
